layer_rr_arbiter: RTL and testbench
===================================

Name: layer_rr_arbiter

Overview:
- Round-robin arbiter that shares one fully-connected layer instance (valid/ready streaming: N input words in, M output words out) between R independent requesters.
- Grants the layer to one requester per transaction. Forwards that requester's N-word input vector, then routes the M result words back to the same requester.
- Sits between the upstream producers and a single layer_* module; purely control plus muxing, no data buffering.

Parameters:
- R, 2, number of requesters (2..8)
- N, 4, input words per transaction (matches layer N)
- M, 3, output words per transaction (matches layer M)
- T, 8, data word width in bits

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- s_valid  input  R  per-requester input-word valid
- s_ready  output  R  per-requester input-word ready
- data_in  input  R*T  per-requester input word; requester i occupies bits [i*T +: T]
- m_valid  output  R  per-requester result-word valid
- m_ready  input  R  per-requester result-word ready
- data_out  output  T  result word, broadcast to all requesters (qualify with m_valid)
- l_s_valid  output  1  valid to layer input
- l_s_ready  input  1  ready from layer input
- l_data_in  output  T  word to layer input
- l_m_valid  input  1  valid from layer output
- l_m_ready  output  1  ready to layer output
- l_data_out  input  T  word from layer output
- grant  output  $clog2(R)  index of the current/last granted requester
- busy  output  1  high in LOAD or DRAIN

Behaviour:
- One clock (clk). reset is asynchronous, active-high.
- On reset:
  - state=IDLE, in_cnt=0, out_cnt=0
  - last pointer=R-1, so requester 0 has first priority
  - grant=0, busy=0
  - all s_ready, m_valid, l_s_valid and l_m_ready are 0 (combinationally forced while reset is high)
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - Search s_valid starting at (last+1) mod R, wrapping.
  - The first asserted requester is registered as grant; next state is LOAD.
  - If none is asserted, stay in IDLE.
  - No handshakes complete in IDLE, including the granting cycle.
- LOAD:
  - Combinational pass-through: l_s_valid=s_valid[grant], s_ready[grant]=l_s_ready, l_data_in=data_in[grant].
  - Other requesters: s_ready=0.
  - Each l_s_valid&&l_s_ready increments in_cnt.
  - A handshake with in_cnt==N-1 clears in_cnt and moves to DRAIN.
- DRAIN:
  - m_valid[grant]=l_m_valid, l_m_ready=m_ready[grant], data_out=l_data_out.
  - Other requesters: m_valid=0.
  - Each l_m_valid&&l_m_ready increments out_cnt.
  - A handshake with out_cnt==M-1 clears out_cnt, sets last=grant and moves to IDLE.
- Outside LOAD, l_s_valid=0 and all s_ready=0. Outside DRAIN, l_m_ready=0 and all m_valid=0.
- data_out=0 when not in DRAIN.
- Latency: zero added cycles on the data path. One arbitration bubble (the IDLE cycle) per transaction.
- A granted requester that drops s_valid mid-vector stalls LOAD. There is no timeout and no regrant.
- Stalls on m_ready in DRAIN are held indefinitely. Data must stay stable because the layer holds its output while l_m_ready=0.
- Simultaneous s_valid from all requesters: grant rotates strictly 0,1,...,R-1,0.
- A single persistent requester is re-granted every transaction after one IDLE cycle.
- Counters are $clog2(max(N,M)+1) bits wide. No wrap beyond N-1 or M-1.
- grant holds its value in IDLE until the next grant.
- Reset asserted mid-LOAD or mid-DRAIN returns immediately to the reset state. The partial transaction is discarded. The layer shares the same reset.

Optional Feature:
- Macro LAYER_ARB_PERF_EN.
- Defined:
  - Extra output perf_cnt, width R*16.
  - One 16-bit saturating counter per requester, incremented on the cycle its transaction completes (final DRAIN handshake).
  - Holds at 16'hFFFF when saturated.
  - Reset to 0.
- Undefined: the perf_cnt port and its counters do not exist. All other behaviour is identical.

Test Plan:
- Single requester, R=2, N=4, M=3, T=8; requester 0 sends 1,2,3,4; layer stub returns 10,20,30 -> l_data_in sequence 1,2,3,4; m_valid[0] pulses with data_out 10,20,30; m_valid[1] never high; grant=0; busy falls after the 3rd output handshake.
- Both requesters hold s_valid continuously for 4 transactions -> grant sequence 0,1,0,1; exactly one IDLE cycle between transactions; each requester receives only its own 3 results.
- Requester 0 drops s_valid for 5 cycles after word 2 while requester 1 is valid -> LOAD stalls, in_cnt stays 2, s_ready[1]=0 throughout; requester 0 completes, then requester 1 is granted.
- m_ready[1]=0 for 6 cycles during DRAIN of requester 1 -> l_m_ready=0, data_out stable, no count advance; resumes and completes with 3 words.
- Reset asserted asynchronously mid-DRAIN (out_cnt=1) -> all outputs 0 immediately; after release, requester 0 is served first on a new transaction.
- With LAYER_ARB_PERF_EN: 5 transactions to requester 1 and 2 to requester 0 -> perf_cnt[31:16]=5, perf_cnt[15:0]=2.

Source files
------------

// File: rtl/layer_rr_arbiter.sv
// layer_rr_arbiter: round-robin sharing of one valid/ready layer between R requesters; zero added data latency,
// one IDLE arbitration cycle per transaction, stalls pass straight through. LAYER_ARB_PERF_EN adds perf_cnt.
module layer_rr_arbiter #(
  parameter int R = 2,
  parameter int N = 4,
  parameter int M = 3,
  parameter int T = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         s_valid,
  output logic [R-1:0]         s_ready,
  input  logic [R*T-1:0]       data_in,
  output logic [R-1:0]         m_valid,
  input  logic [R-1:0]         m_ready,
  output logic [T-1:0]         data_out,
  output logic                 l_s_valid,
  input  logic                 l_s_ready,
  output logic [T-1:0]         l_data_in,
  input  logic                 l_m_valid,
  output logic                 l_m_ready,
  input  logic [T-1:0]         l_data_out,
  output logic [$clog2(R)-1:0] grant,
  output logic                 busy
`ifdef LAYER_ARB_PERF_EN
  ,
  output logic [R*16-1:0]      perf_cnt
`endif
);
  localparam int GW = $clog2(R);
  localparam int CW = $clog2(((N > M) ? N : M) + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] last;
  logic [GW-1:0] last_nxt;
  logic [GW-1:0] grant_nxt;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] in_cnt_nxt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      last    <= GW'(R - 1);
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      last    <= last_nxt;
      in_cnt  <= in_cnt_nxt;
      out_cnt <= out_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    s_ready     = '0;
    m_valid     = '0;
    l_s_valid   = 1'b0;
    l_m_ready   = 1'b0;
    l_data_in   = '0;
    data_out    = '0;

    case (state)
      IDLE: begin
        // Scan from farthest to nearest so the requester right after last wins.
        for (int i = R; i >= 1; i--) begin
          if (s_valid[GW'((int'(last) + i) % R)]) begin
            grant_nxt = GW'((int'(last) + i) % R);
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        l_s_valid      = s_valid[grant];
        s_ready[grant] = l_s_ready;
        l_data_in      = data_in[grant*T +: T];
        if (l_s_valid && l_s_ready) begin
          if (in_cnt == CW'(N - 1)) begin
            in_cnt_nxt = '0;
            state_nxt  = DRAIN;
          end else begin
            in_cnt_nxt = in_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        m_valid[grant] = l_m_valid;
        l_m_ready      = m_ready[grant];
        data_out       = l_data_out;
        if (l_m_valid && l_m_ready) begin
          if (out_cnt == CW'(M - 1)) begin
            out_cnt_nxt = '0;
            last_nxt    = grant;
            state_nxt   = IDLE;
          end else begin
            out_cnt_nxt = out_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Handshake outputs are forced low for the whole reset pulse, not just after the flops clear.
    if (reset) begin
      s_ready   = '0;
      m_valid   = '0;
      l_s_valid = 1'b0;
      l_m_ready = 1'b0;
      l_data_in = '0;
      data_out  = '0;
    end
  end

  assign busy = (state != IDLE);

`ifdef LAYER_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt <= '0;
    end else if (l_m_valid && l_m_ready && out_cnt == CW'(M - 1)) begin
      for (int i = 0; i < R; i++) begin
        if (grant == GW'(i) && perf_cnt[i*16 +: 16] != 16'hFFFF) begin
          perf_cnt[i*16 +: 16] <= perf_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_rr_arbiter.sv
// Bench for layer_rr_arbiter: requester/consumer/layer stubs plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_layer_rr_arbiter;
  localparam int R = 2;
  localparam int N = 4;
  localparam int M = 3;
  localparam int T = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [R-1:0]         s_valid, s_ready, m_valid, m_ready;
  logic [R*T-1:0]       data_in;
  logic [T-1:0]         data_out, l_data_in, l_data_out;
  logic                 l_s_valid, l_s_ready, l_m_valid, l_m_ready;
  logic [$clog2(R)-1:0] grant;
  logic                 busy;
`ifdef LAYER_ARB_PERF_EN
  logic [R*16-1:0]      perf_cnt;
`endif

  layer_rr_arbiter #(.R(R), .N(N), .M(M), .T(T)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
    .l_s_valid(l_s_valid), .l_s_ready(l_s_ready), .l_data_in(l_data_in),
    .l_m_valid(l_m_valid), .l_m_ready(l_m_ready), .l_data_out(l_data_out),
    .grant(grant), .busy(busy)
`ifdef LAYER_ARB_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [T-1:0] src_q [R][$];
  int           exp_q [R][$];
  int           rx_log [R][$];
  int           stub_log [$];
  int           grant_log [$];
  int           gap_log [$];
  logic [R-1:0] src_en   = '1;
  logic [R-1:0] sink_rdy = '1;
  int           sent_cnt [R];
  int           recv_cnt [R];
  int           gap_at [R];
  int           gap_len [R];
  int           stall_at [R];
  int           stall_len [R];
  logic [T-1:0] stub_w0 = '0;
  int           stub_in = 0;
  int           stub_out = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string name, input int got[$], input int n, input int e[8]);
    chk({name, "_len"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++) chk($sformatf("%s[%0d]", name, k), got[k], e[k]);
  endtask

  function automatic logic bitof(input logic [R-1:0] v, input int i);
    return ((v >> i) & R'(1)) != '0;
  endfunction

  // Layer result k of a vector whose first word is w0: w0*10*(k+1).
  task automatic push_vec(input int r, input int w0);
    for (int k = 0; k < N; k++) src_q[r].push_back(T'(w0 + k));
    for (int k = 0; k < M; k++) exp_q[r].push_back((w0 * 10 * (k + 1)) & 8'hFF);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < R; i++) rx_log[i].delete();
    stub_log.delete();
    grant_log.delete();
    gap_log.delete();
  endtask

  task automatic wait_done(input string name, input int bound);
    int c = 0;
    while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size() != 0 || busy)
           && c < bound) begin
      @(posedge clk); #2;
      c++;
    end
    n_checks++;
    if (c >= bound) begin
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want done", name, c);
    end
  endtask

  // Requesters, consumers and the layer stub; handshakes sampled at negedge, applied after posedge.
  initial begin : driver
    logic [R-1:0] hs_s, hs_m;
    logic         hs_li, hs_lo, v, rdy;
    logic [T-1:0] li, dq;
    s_valid = '0; m_ready = '0; data_in = '0;
    l_s_ready = 1'b0; l_m_valid = 1'b0; l_data_out = '0;
    forever begin
      @(negedge clk);
      hs_s  = s_valid & s_ready;
      hs_m  = m_valid & m_ready;
      hs_li = l_s_valid && l_s_ready;
      hs_lo = l_m_valid && l_m_ready;
      li    = l_data_in;
      dq    = data_out;
      @(posedge clk); #1;
      if (reset) begin
        stub_in = 0;
        stub_out = 0;
      end else begin
        for (int i = 0; i < R; i++) begin
          if (bitof(hs_s, i)) begin void'(src_q[i].pop_front()); sent_cnt[i]++; end
          if (bitof(hs_m, i)) begin rx_log[i].push_back(int'(dq)); recv_cnt[i]++; end
        end
        if (hs_li) begin
          if (stub_in == 0) stub_w0 = li;
          stub_log.push_back(int'(li));
          stub_in++;
        end
        if (hs_lo) begin
          stub_out++;
          if (stub_out == M) begin stub_in = 0; stub_out = 0; end
        end
      end
      for (int i = 0; i < R; i++) begin
        v = src_en[i] && src_q[i].size() != 0;
        if (v && sent_cnt[i] == gap_at[i] && gap_len[i] > 0) begin v = 1'b0; gap_len[i]--; end
        s_valid[i] = v;
        data_in[i*T +: T] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        rdy = sink_rdy[i];
        if (recv_cnt[i] == stall_at[i] && stall_len[i] > 0) begin rdy = 1'b0; stall_len[i]--; end
        m_ready[i] = rdy;
      end
      l_s_ready  = (stub_in < N);
      l_m_valid  = (stub_in == N);
      l_data_out = l_m_valid ? T'(int'(stub_w0) * 10 * (stub_out + 1)) : '0;
    end
  end

  // Transaction-level reference: owner, phase and word counts derived from the arbitration rules.
  initial begin : compare
    int ph, mg, mlast, cnt, idle_run, idx, want;
    logic prev_busy, prev_stall;
    logic [T-1:0] prev_dout, exp_li, exp_do;
    logic [R-1:0] exp_sr, exp_mv;
    logic exp_lsv, exp_lmr;
    ph = 0; mg = 0; mlast = R - 1; cnt = 0; idle_run = 0;
    prev_busy = 1'b0; prev_stall = 1'b0; prev_dout = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_l_s_valid", l_s_valid, 0);
        chk("rst_l_m_ready", l_m_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        ph = 0; mg = 0; mlast = R - 1; cnt = 0; idle_run = 0;
        prev_busy = 1'b0; prev_stall = 1'b0;
        continue;
      end
      chk("grant", grant, mg);
      chk("busy", busy, ph != 0);
      if (busy && !prev_busy) begin
        grant_log.push_back(int'(grant));
        gap_log.push_back(idle_run);
        idle_run = 0;
      end
      if (!busy) idle_run++;
      prev_busy = busy;

      exp_sr = '0; exp_mv = '0; exp_lsv = 1'b0; exp_lmr = 1'b0; exp_li = '0; exp_do = '0;
      if (ph == 1) begin
        exp_lsv = bitof(s_valid, mg);
        exp_sr  = R'(l_s_ready) << mg;
        exp_li  = T'(data_in >> (mg * T));
      end else if (ph == 2) begin
        exp_mv  = R'(l_m_valid) << mg;
        exp_lmr = bitof(m_ready, mg);
        exp_do  = l_data_out;
      end
      chk("s_ready", s_ready, exp_sr);
      chk("l_s_valid", l_s_valid, exp_lsv);
      chk("l_data_in", l_data_in, exp_li);
      chk("m_valid", m_valid, exp_mv);
      chk("l_m_ready", l_m_ready, exp_lmr);
      chk("data_out", data_out, exp_do);
      if (ph == 2 && prev_stall) chk("data_out_hold", data_out, prev_dout);
      prev_stall = (ph == 2) && l_m_valid && !exp_lmr;
      prev_dout  = data_out;

      case (ph)
        0: if (s_valid != '0) begin
          for (int k = 1; k <= R; k++) begin
            idx = (mlast + k) % R;
            if (bitof(s_valid, idx)) begin mg = idx; break; end
          end
          ph = 1;
        end
        1: if (exp_lsv && l_s_ready) begin
          cnt++;
          if (cnt == N) begin cnt = 0; ph = 2; end
        end
        default: if (l_m_valid && exp_lmr) begin
          if (exp_q[mg].size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_result: requester %0d got %0d, want no result", mg, data_out);
          end else begin
            want = exp_q[mg].pop_front();
            chk($sformatf("result_r%0d", mg), data_out, want);
          end
          cnt++;
          if (cnt == M) begin cnt = 0; ph = 0; mlast = mg; end
        end
      endcase
    end
  end

  initial begin : sequence_main
    int c;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    chk("reset_s_ready", s_ready, 0);
    @(posedge clk); #3;
    reset = 1'b0;

    // Single requester 0
    @(posedge clk); #2;
    clear_logs();
    push_vec(0, 1);
    wait_done("single", 60);
    chk_seq("single_layer_in", stub_log, 4, '{1, 2, 3, 4, 0, 0, 0, 0});
    chk_seq("single_rx0", rx_log[0], 3, '{10, 20, 30, 0, 0, 0, 0, 0});
    chk("single_rx1_len", rx_log[1].size(), 0);
    chk_seq("single_grant", grant_log, 1, '{0, 0, 0, 0, 0, 0, 0, 0});

    // m_ready[1] stalled for 6 cycles after its first result
    clear_logs();
    push_vec(1, 7);
    stall_at[1] = recv_cnt[1] + 1;
    stall_len[1] = 6;
    wait_done("stall", 80);
    chk_seq("stall_rx1", rx_log[1], 3, '{70, 140, 210, 0, 0, 0, 0, 0});
    chk("stall_consumed", stall_len[1], 0);

    // Both requesters continuously valid
    clear_logs();
    push_vec(0, 1); push_vec(1, 2); push_vec(0, 3); push_vec(1, 4);
    wait_done("rotate", 150);
    chk_seq("rotate_grant", grant_log, 4, '{0, 1, 0, 1, 0, 0, 0, 0});
    for (int k = 1; k < 4 && k < gap_log.size(); k++) chk($sformatf("rotate_idle_gap%0d", k), gap_log[k], 1);
    chk_seq("rotate_rx0", rx_log[0], 6, '{10, 20, 30, 30, 60, 90, 0, 0});
    chk_seq("rotate_rx1", rx_log[1], 6, '{20, 40, 60, 40, 80, 120, 0, 0});

    // Requester 0 pauses mid-vector while requester 1 waits
    clear_logs();
    push_vec(0, 5); push_vec(1, 6);
    gap_at[0] = sent_cnt[0] + 2;
    gap_len[0] = 5;
    wait_done("pause", 120);
    chk_seq("pause_grant", grant_log, 2, '{0, 1, 0, 0, 0, 0, 0, 0});
    chk_seq("pause_layer_in", stub_log, 8, '{5, 6, 7, 8, 6, 7, 8, 9});
    chk("pause_consumed", gap_len[0], 0);

    // Reset during requester 1 DRAIN, with last pointing at requester 0
    push_vec(0, 2);
    wait_done("pre_reset", 60);
    clear_logs();
    push_vec(1, 3);
    c = 0;
    while (rx_log[1].size() < 1 && c < 60) begin @(posedge clk); #2; c++; end
    chk("reset_mid_drain_reached", rx_log[1].size(), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_grant", grant, 0);
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_l_m_ready", l_m_ready, 0);
    chk("async_rst_data_out", data_out, 0);
    @(posedge clk); #2;
    for (int i = 0; i < R; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    clear_logs();
    push_vec(0, 4); push_vec(1, 5);
    @(posedge clk); #3;
    reset = 1'b0;
    wait_done("post_reset", 100);
    chk_seq("post_reset_grant", grant_log, 2, '{0, 1, 0, 0, 0, 0, 0, 0});
    chk_seq("post_reset_rx0", rx_log[0], 3, '{40, 80, 120, 0, 0, 0, 0, 0});
    chk_seq("post_reset_rx1", rx_log[1], 3, '{50, 100, 150, 0, 0, 0, 0, 0});

    // Extra traffic: four more for requester 1, one more for requester 0
    clear_logs();
    push_vec(1, 1); push_vec(1, 2); push_vec(1, 3); push_vec(1, 4); push_vec(0, 8);
    wait_done("extra", 250);
    chk_seq("extra_grant", grant_log, 5, '{0, 1, 1, 1, 1, 0, 0, 0});
`ifdef LAYER_ARB_PERF_EN
    chk("perf_r1", perf_cnt[31:16], 5);
    chk("perf_r0", perf_cnt[15:0], 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
